// File: rtl/icache_l1_nway.sv
// L1 instruction cache: N-way set-associative, tree pseudo-LRU,
// L2 line refill over valid/ready beats, fence.i full invalidate.
module icache_l1_nway #(
  parameter int S = 32,
  parameter int E = 4,
  parameter int B = 64,
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         fetch_en_i,
  input  logic [31:0]  pc_f_i,
  input  logic         inv_i,
  output logic [31:0]  instr_f_o,
  output logic         instr_hit_f_o,
  output logic         busy_o,
  output logic         l2_req_o,
  output logic [31:0]  l2_addr_o,
  input  logic         l2_req_ready_i,
  input  logic         l2_data_valid_i,
  input  logic [W-1:0] l2_data_i
);

  localparam int OW  = $clog2(B);
  localparam int SW  = $clog2(S);
  localparam int TW  = 32 - OW - SW;
  localparam int WW  = $clog2(E);
  localparam int NB  = 8 * B / W;
  localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int WIW = OW - 2;
  localparam int WPB = W / 32;

  typedef enum logic [1:0] {
    IDLE, REQ, FILL, INV
  } state_t;

  // Walk the tree from the root; a 1 sends us to the upper half.
  function automatic logic [WW-1:0] plru_victim(
    input logic [E-2:0] p
  );
    int n;
    n = 0;
    for (int l = 0; l < WW; l++)
      n = p[n] ? 2 * n + 2 : 2 * n + 1;
    return WW'(n - (E - 1));
  endfunction

  // Point every node on the accessed path away from way w.
  function automatic logic [E-2:0] plru_touch(
    input logic [E-2:0] p,
    input logic [WW-1:0] w
  );
    logic [E-2:0] r;
    int n;
    r = p;
    n = 0;
    for (int l = 0; l < WW; l++) begin
      r[n] = ~w[WW-1-l];
      n = w[WW-1-l] ? 2 * n + 2 : 2 * n + 1;
    end
    return r;
  endfunction

  logic [E-1:0]  vld_q  [S];
  logic [E-2:0]  plru_q [S];
  logic [TW-1:0] tags_q [S][E];
  logic [W-1:0]  data_q [S][E][NB];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [SW-1:0] inv_set_q, inv_set_d;
  logic [31:0]   line_q, line_d;
  logic [SW-1:0] mset_q, mset_d;
  logic [TW-1:0] mtag_q, mtag_d;
  logic [WW-1:0] way_q, way_d;

  logic [SW-1:0]  set_f;
  logic [TW-1:0]  tag_f;
  logic [WIW-1:0] widx;
  logic [CW-1:0]  beat_rd;
  logic [31:0]    wsel;
  logic           hit_any;
  logic [WW-1:0]  hit_way;
  logic [WW-1:0]  victim;
  logic [W-1:0]   rd_beat;
  logic [W-1:0]   rd_sh;
  logic           beat_en;
  logic           fill_done;
  logic           unused_pc;

  assign set_f     = pc_f_i[OW+SW-1:OW];
  assign tag_f     = pc_f_i[31:OW+SW];
  assign widx      = pc_f_i[OW-1:2];
  assign beat_rd   = CW'(32'(widx) / WPB);
  assign wsel      = 32'(widx) % WPB;
  assign unused_pc = ^pc_f_i[1:0];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int i = 0; i < E; i++) begin
      if (vld_q[set_f][i] && tags_q[set_f][i] == tag_f) begin
        hit_any = 1'b1;
        hit_way = WW'(i);
      end
    end
  end

  // Lowest invalid way wins; otherwise fall back to the PLRU victim.
  always_comb begin
    victim = plru_victim(plru_q[set_f]);
    for (int i = E - 1; i >= 0; i--)
      if (!vld_q[set_f][i]) victim = WW'(i);
  end

  // Word select from the hit line.
  always_comb begin
    rd_beat = data_q[set_f][hit_way][beat_rd];
    rd_sh   = rd_beat >> (32 * wsel);
  end

  assign instr_hit_f_o = (state_q == IDLE) & fetch_en_i & hit_any;
  assign instr_f_o     = instr_hit_f_o ? rd_sh[31:0] : 32'h0;
  assign busy_o        = (state_q != IDLE);
  assign l2_req_o      = (state_q == REQ);
  assign l2_addr_o     = (state_q == REQ) ? line_q : 32'h0;

  assign beat_en = l2_data_valid_i &
                   ((state_q == FILL) |
                    ((state_q == REQ) & l2_req_ready_i));
  assign fill_done = beat_en & (cnt_q == CW'(NB - 1));

  // Refill / invalidate sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    inv_set_d = inv_set_q;
    line_d    = line_q;
    mset_d    = mset_q;
    mtag_d    = mtag_q;
    way_d     = way_q;
    unique case (state_q)
      IDLE: begin
        if (inv_i) begin
          state_d   = INV;
          inv_set_d = '0;
        end else if (fetch_en_i && !hit_any) begin
          state_d = REQ;
          line_d  = {pc_f_i[31:OW], {OW{1'b0}}};
          mset_d  = set_f;
          mtag_d  = tag_f;
          way_d   = victim;
        end
      end
      REQ: begin
        if (inv_i) pend_d = 1'b1;
        if (l2_req_ready_i) state_d = FILL;
      end
      FILL: begin
        if (inv_i) pend_d = 1'b1;
      end
      INV: begin
        inv_set_d = inv_set_q + 1'b1;
        if (inv_set_q == SW'(S - 1)) begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end
      end
    endcase
    if (beat_en) cnt_d = cnt_q + 1'b1;
    if (fill_done) begin
      cnt_d     = '0;
      inv_set_d = '0;
      state_d   = (pend_q | inv_i) ? INV : IDLE;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      inv_set_q <= '0;
      line_q    <= '0;
      mset_q    <= '0;
      mtag_q    <= '0;
      way_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      inv_set_q <= inv_set_d;
      line_q    <= line_d;
      mset_q    <= mset_d;
      mtag_q    <= mtag_d;
      way_q     <= way_d;
    end
  end

  // Valid and PLRU arrays; fill completion overrides the first-beat clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int s = 0; s < S; s++) begin
        vld_q[s]  <= '0;
        plru_q[s] <= '0;
      end
    end else begin
      if (state_q == INV) begin
        vld_q[inv_set_q]  <= '0;
        plru_q[inv_set_q] <= '0;
      end
      if (instr_hit_f_o)
        plru_q[set_f] <= plru_touch(plru_q[set_f], hit_way);
      if (beat_en && cnt_q == '0)
        vld_q[mset_q][way_q] <= 1'b0;
      if (fill_done) begin
        vld_q[mset_q][way_q] <= 1'b1;
        plru_q[mset_q] <= plru_touch(plru_q[mset_q], way_q);
      end
    end
  end

  // Line data and tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (beat_en)
      data_q[mset_q][way_q][cnt_q] <= l2_data_i;
    if (fill_done)
      tags_q[mset_q][way_q] <= mtag_q;
  end

endmodule

// File: tb/tb_icache_l1_nway.sv
// Bench for icache_l1_nway: directed fetch/refill/invalidate vectors,
// expected lookups and L2 requests checked by a queue-driven monitor.
module tb_icache_l1_nway;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        inv = 1'b0;
  logic [31:0] instr;
  logic        hit;
  logic        busy;
  logic        req;
  logic [31:0] req_addr;
  logic        req_ready = 1'b0;
  logic        dvalid = 1'b0;
  logic [63:0] ddata = 64'h0;

  icache_l1_nway dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .fetch_en_i      (fetch_en),
    .pc_f_i          (pc),
    .inv_i           (inv),
    .instr_f_o       (instr),
    .instr_hit_f_o   (hit),
    .busy_o          (busy),
    .l2_req_o        (req),
    .l2_addr_o       (req_addr),
    .l2_req_ready_i  (req_ready),
    .l2_data_valid_i (dvalid),
    .l2_data_i       (ddata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] instr;
  } lk_t;

  lk_t         lk_q [$];
  logic [31:0] rq_q [$];
  int vectors = 0;
  int miscompares = 0;
  int busy_cnt = 0;
  int req_cnt = 0;

  function automatic logic [31:0] wexp(
    input logic [31:0] a, input logic [31:0] seed
  );
    return {a[31:2], 2'b00} ^ seed;
  endfunction

  function automatic logic [63:0] beat(
    input logic [31:0] line, input logic [31:0] seed, input int b
  );
    logic [31:0] a;
    a = line + 32'(8 * b);
    return {wexp(a + 32'd4, seed), wexp(a, seed)};
  endfunction

  task automatic check(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT
  // is presented a lookup or drives an L2 request.
  initial forever begin
    lk_t e;
    @(negedge clk);
    if (fetch_en) begin
      if (lk_q.size() == 0) begin
        miscompares++;
        $display("FAIL lookup_unexpected: pc %h", pc);
      end else begin
        e = lk_q.pop_front();
        vectors++;
        if (hit !== e.hit || instr !== e.instr) begin
          miscompares++;
          $display("FAIL lookup pc=%h: got hit=%b instr=%h want hit=%b instr=%h",
                   pc, hit, instr, e.hit, e.instr);
        end
      end
    end
    if (req) begin
      if (rq_q.size() == 0) begin
        miscompares++;
        $display("FAIL l2_req_unexpected: addr %h", req_addr);
      end else begin
        vectors++;
        if (req_addr !== rq_q[0]) begin
          miscompares++;
          $display("FAIL l2_addr: got %h want %h", req_addr, rq_q[0]);
        end
        if (req_ready) void'(rq_q.pop_front());
      end
    end
    if (busy) busy_cnt++;
    if (req) req_cnt++;
  end

  task automatic lookup_raw(input logic [31:0] a);
    pc = a;
    fetch_en = 1'b1;
    @(posedge clk); #1;
    fetch_en = 1'b0;
  endtask

  task automatic lookup(
    input logic [31:0] a, input logic h, input logic [31:0] w
  );
    lk_q.push_back('{h, w});
    lookup_raw(a);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  // Miss at pc, then act as L2: ready after rdy request cycles,
  // optional beat 0 in the ready cycle, optional inv or reset pulse.
  task automatic miss_fill(
    input logic [31:0] a, input logic [31:0] seed, input int rdy,
    input bit early, input int inv_beat, input int abort_beat
  );
    logic [31:0] line;
    int n;
    int b0;
    line = {a[31:6], 6'b0};
    rq_q.push_back(line);
    lookup(a, 1'b0, 32'h0);
    n = 0;
    while (!req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req) begin
      miscompares++;
      $display("FAIL req_timeout: got l2_req 0 want 1 for %h", line);
      return;
    end
    for (int i = 1; i < rdy; i++) begin
      @(posedge clk); #1;
    end
    req_ready = 1'b1;
    b0 = 0;
    if (early) begin
      dvalid = 1'b1;
      ddata = beat(line, seed, 0);
      b0 = 1;
    end
    @(posedge clk); #1;
    req_ready = 1'b0;
    dvalid = 1'b0;
    for (int b = b0; b < 8; b++) begin
      dvalid = 1'b1;
      ddata = beat(line, seed, b);
      if (b == abort_beat) begin
        reset_n = 1'b0;
        dvalid = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_req", {31'h0, req}, 32'h0);
        check("abort_hit", {31'h0, hit}, 32'h0);
        check("abort_addr", req_addr, 32'h0);
        check("abort_instr", instr, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        return;
      end
      if (b == inv_beat) inv = 1'b1;
      @(posedge clk); #1;
      inv = 1'b0;
    end
    dvalid = 1'b0;
  endtask

  localparam logic [31:0] SA = 32'h1111_0000;
  localparam logic [31:0] SB = 32'h2222_0000;
  localparam logic [31:0] SC = 32'h3333_0000;
  localparam logic [31:0] SD = 32'h4444_0000;
  localparam logic [31:0] SE = 32'h5555_0000;
  localparam logic [31:0] SF = 32'h6666_0000;
  localparam logic [31:0] SG = 32'h7777_0000;
  localparam logic [31:0] SH = 32'h8888_0000;
  localparam logic [31:0] SI = 32'h9999_0000;
  localparam logic [31:0] SK = 32'hBBBB_0000;

  initial begin
    logic [31:0] acc;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hit", {31'h0, hit}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_req", {31'h0, req}, 32'h0);
    check("rst_addr", req_addr, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    busy_cnt = 0;
    req_cnt = 0;
    miss_fill(32'h1004, SA, 3, 1'b0, -1, -1);
    check("cold_busy", busy_cnt, 11);
    check("cold_req", req_cnt, 3);
    lookup(32'h1004, 1'b1, 32'h1004 ^ SA);
    for (int i = 0; i < 16; i++)
      lookup(32'h1000 + 32'(4 * i), 1'b1,
             (32'h1000 + 32'(4 * i)) ^ SA);

    busy_cnt = 0;
    miss_fill(32'h2000, SB, 1, 1'b1, -1, -1);
    check("early_busy", busy_cnt, 8);
    miss_fill(32'h3000, SC, 2, 1'b0, -1, -1);
    miss_fill(32'h4000, SD, 2, 1'b0, -1, -1);
    lookup(32'h1000, 1'b1, 32'h1000 ^ SA);
    miss_fill(32'h5008, SE, 2, 1'b0, -1, -1);
    lookup(32'h5008, 1'b1, 32'h5008 ^ SE);
    lookup(32'h1000, 1'b1, 32'h1000 ^ SA);
    lookup(32'h2004, 1'b1, 32'h2004 ^ SB);
    lookup(32'h403C, 1'b1, 32'h403C ^ SD);
    miss_fill(32'h3000, SC, 2, 1'b0, -1, -1);
    lookup(32'h3010, 1'b1, 32'h3010 ^ SC);

    busy_cnt = 0;
    inv = 1'b1;
    @(posedge clk); #1;
    inv = 1'b0;
    wait_idle();
    check("inv_busy", busy_cnt, 32);
    acc = 32'h0;
    for (int s = 0; s < 32; s++)
      acc = acc | 32'(dut.plru_q[s]);
    check("inv_plru", acc, 32'h0);
    miss_fill(32'h1004, SF, 2, 1'b0, -1, -1);
    miss_fill(32'h2004, SG, 2, 1'b0, -1, -1);
    lookup(32'h1004, 1'b1, 32'h1004 ^ SF);

    busy_cnt = 0;
    miss_fill(32'h6004, SH, 2, 1'b0, 3, -1);
    inv = 1'b1;
    @(posedge clk); #1;
    inv = 1'b0;
    wait_idle();
    check("fillinv_busy", busy_cnt, 42);
    miss_fill(32'h6004, SI, 2, 1'b0, -1, -1);
    lookup(32'h6004, 1'b1, 32'h6004 ^ SI);

    miss_fill(32'h1004, SK, 2, 1'b0, -1, -1);
    lookup(32'h1004, 1'b1, 32'h1004 ^ SK);
    miss_fill(32'h2004, SA, 2, 1'b0, -1, 4);
    miss_fill(32'h1004, SB, 2, 1'b0, -1, -1);
    lookup(32'h1004, 1'b1, 32'h1004 ^ SB);
    miss_fill(32'h6004, SC, 2, 1'b0, -1, -1);
    lookup(32'h6008, 1'b1, 32'h6008 ^ SC);

    repeat (3) @(posedge clk);
    #1;
    check("lk_q_empty", 32'(lk_q.size()), 32'h0);
    check("rq_q_empty", 32'(rq_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
